// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
//
// Stall controller for the single-cycle RV32I core. NUM_CH memory requesters
// share one slow (SRAM) port. Slow accesses of the current instruction are
// serialised with a fixed-priority grant, where channel 0 has the highest
// priority. PC and regfile writeback stay frozen until every slow access has
// been acknowledged. Fast-memory side effects are then allowed in exactly one
// commit cycle (DONE).
//
// Optional feature (compile-time macro): MEM_STALL_TIMEOUT_EN
//   Defined   : a per-grant watchdog retires the granted channel after
//               TIMEOUT_CYCLES cycles without i_ack, and sets the sticky
//               o_timeout flag.
//   Undefined : ACCESS waits for i_ack indefinitely, and o_timeout is tied 0.
//
// Ports
//   i_clk          clock; all state updates on its rising edge
//   i_rst          synchronous, active-high reset
//   i_req_rd       per-channel read request of the current instruction
//   i_req_wr       per-channel write request of the current instruction
//   i_slow         per-channel: target is the slow port and needs i_ack
//   i_ack          slow port finished the granted access (1-cycle pulse)
//   o_grant        one-hot owner of the slow port; 0 when idle (registered)
//   o_mem_en       per-channel enable ANDed onto rden/wren
//   o_pc_wren      PC / debug-PC update enable
//   o_rd_wren_en   regfile write permission
//   o_busy         stall in progress (state != IDLE)
//   o_stall_cycles saturating count of cycles with o_pc_wren = 0
//   o_timeout      sticky timeout flag
//   o_state        FSM state for debug (0 = IDLE, 1 = ACCESS, 2 = DONE)
//
// Handshake: a channel is "slow-requesting" when i_slow & (i_req_rd | i_req_wr).
// The slow port owns an access while o_grant shows it. The access completes on
// the single cycle i_ack is high while in ACCESS; an i_ack seen in any other
// state is ignored.
// -----------------------------------------------------------------------------
module mem_stall_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_req_rd,
    input  logic [NUM_CH-1:0] i_req_wr,
    input  logic [NUM_CH-1:0] i_slow,
    input  logic              i_ack,
    output logic [NUM_CH-1:0] o_grant,
    output logic [NUM_CH-1:0] o_mem_en,
    output logic              o_pc_wren,
    output logic              o_rd_wren_en,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output logic              o_timeout,
    output logic [1:0]        o_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] grant_q;
    logic [CNT_W-1:0]  stall_q;
    logic [NUM_CH-1:0] slow_req;
    logic [NUM_CH-1:0] remaining;
    logic              retire;
    logic              tmo_hit;

    // Isolate the lowest set bit, i.e. the highest-priority channel.
    function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign slow_req  = i_slow & (i_req_rd | i_req_wr);
    assign retire    = (state_q == ST_ACCESS) && (i_ack || tmo_hit);
    assign remaining = pending_q & ~grant_q;

    // -------------------------------------------------------------------------
    // Main FSM. The pending set is latched once, when the instruction first
    // shows a slow request. Request changes after that point are ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (slow_req != '0) begin
                        pending_q <= slow_req;
                        grant_q   <= lowest_bit(slow_req);
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (retire) begin
                        pending_q <= remaining;
                        // Handover to the next channel takes effect on the
                        // cycle right after the ack.
                        grant_q   <= lowest_bit(remaining);
                        if (remaining == '0) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pending_q <= '0;
                    grant_q   <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Enables. Everything is held low while reset is asserted, so that a
    // half-decoded instruction cannot commit during the reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        o_pc_wren    = 1'b0;
        o_rd_wren_en = 1'b0;
        o_mem_en     = '0;
        if (!i_rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (slow_req == '0) begin
                        o_pc_wren    = 1'b1;
                        o_rd_wren_en = 1'b1;
                        o_mem_en     = '1;
                    end
                end
                ST_ACCESS: begin
                    o_mem_en = grant_q;
                end
                ST_DONE: begin
                    // Slow channels already completed; only fast ones fire now.
                    o_pc_wren    = 1'b1;
                    o_rd_wren_en = 1'b1;
                    o_mem_en     = ~i_slow;
                end
                default: begin
                    o_mem_en = '0;
                end
            endcase
        end
    end

    // Saturating count of frozen-PC cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
        end else if (!o_pc_wren && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

`ifdef MEM_STALL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    // Hitting the limit on this cycle means the grant has lasted
    // TIMEOUT_CYCLES cycles without an ack.
    assign tmo_hit = (state_q == ST_ACCESS) && !i_ack &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == ST_ACCESS) && !retire) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                // A retire starts a fresh grant (or leaves ACCESS).
                tmo_cnt_q <= '0;
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;

    // TIMEOUT_CYCLES has no effect without the watchdog, and o_timeout is
    // tied low whatever its value.
    if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
        assign o_timeout = 1'b0;
    end else begin : g_no_watchdog_zero
        assign o_timeout = 1'b0;
    end
`endif

    assign o_grant        = grant_q;
    assign o_busy         = (state_q != ST_IDLE) && !i_rst;
    assign o_stall_cycles = stall_q;
    assign o_state        = state_q;

endmodule
